// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded MIPS32 requests (addu, subu, jr, syscall, ori,
// lui, lw, sw, beq, j, jal) into machine words and queues them, each tagged with
// its text-segment address, in a small circular output FIFO.
// Optional feature macro: ENCODER_STRICT_EN. When it is defined, invalid ops are
// dropped and flagged on a sticky err output. When it is undefined, invalid ops
// are enqueued as a nop and err is held at 0.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_op,
    input  logic [4:0]                    in_rs,
    input  logic [4:0]                    in_rt,
    input  logic [4:0]                    in_rd,
    input  logic [15:0]                   in_imm16,
    input  logic [25:0]                   in_target,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr,
    output logic [31:0]                   out_addr,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        OP_ADDU    = 4'd0,
        OP_SUBU    = 4'd1,
        OP_JR      = 4'd2,
        OP_SYSCALL = 4'd3,
        OP_ORI     = 4'd4,
        OP_LUI     = 4'd5,
        OP_LW      = 4'd6,
        OP_SW      = 4'd7,
        OP_BEQ     = 4'd8,
        OP_J       = 4'd9,
        OP_JAL     = 4'd10
    } op_e;

    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [31:0]   addr_mem  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   next_addr;
    logic [31:0]   word;
    logic          push;
    logic          pop;
    logic          enq;

    assign out_valid = (count != '0);
    assign in_ready  = (count < DEPTH_C) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign out_addr  = out_valid ? addr_mem[rd_ptr]  : '0;

`ifdef ENCODER_STRICT_EN
    logic op_ok;
    assign op_ok = (in_op <= 4'd10);
    assign enq   = push && op_ok;

    // Sticky flag for accepted requests carrying an unsupported op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (push && !op_ok)
            err <= 1'b1;
    end
`else
    assign enq = push;
    assign err = 1'b0;
`endif

    // Field packing; only the fields an op defines reach the word, invalid ops give a nop
    always_comb begin
        word = '0;
        case (op_e'(in_op))
            OP_ADDU:    word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h21};
            OP_SUBU:    word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h23};
            OP_JR:      word = {6'h00, in_rs, 15'b0, 6'h08};
            OP_SYSCALL: word = 32'h0000_000C;
            OP_ORI:     word = {6'h0d, in_rs, in_rt, in_imm16};
            OP_LUI:     word = {6'h0f, 5'b0, in_rt, in_imm16};
            OP_LW:      word = {6'h23, in_rs, in_rt, in_imm16};
            OP_SW:      word = {6'h2b, in_rs, in_rt, in_imm16};
            OP_BEQ:     word = {6'h04, in_rs, in_rt, in_imm16};
            OP_J:       word = {6'h02, in_target};
            OP_JAL:     word = {6'h03, in_target};
            default:    word = '0;
        endcase
    end

    // FIFO storage; contents are don't-care while unoccupied, outputs are masked when empty
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr] <= word;
            addr_mem[wr_ptr]  <= next_addr;
        end
    end

    // Pointers, occupancy and address counter; flush wins over any same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            next_addr <= BASE_ADDR;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            next_addr <= BASE_ADDR;
        end else begin
            if (enq) begin
                wr_ptr    <= wr_ptr + 1'b1;
                next_addr <= next_addr + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, err;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm16;
    logic [25:0] in_target;
    logic [31:0] out_instr, out_addr;
    logic [2:0]  count;

    logic        w_valid, w_in_ready, w_out_valid, w_out_ready, w_err;
    logic [3:0]  w_op;
    logic [31:0] w_instr, w_addr;
    logic [2:0]  w_count;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm16(in_imm16), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .count(count), .err(err)
    );

    instr_encoder #(.BASE_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(w_valid), .in_ready(w_in_ready), .in_op(w_op),
        .in_rs(5'd0), .in_rt(5'd0), .in_rd(5'd0),
        .in_imm16(16'd0), .in_target(26'd0),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_instr(w_instr), .out_addr(w_addr),
        .count(w_count), .err(w_err)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
    } req_t;

    typedef struct {
        req_t        r;
        logic [31:0] exp;
    } vec_t;

    // Reference model state: queued {word, address}, next address, sticky error
    logic [63:0] mq[$];
    logic [31:0] m_addr;
    logic        m_err;

    // Opcode/funct table applied to shifted fields
    function automatic logic [31:0] ref_enc(req_t r);
        logic [31:0] s, t, d, i, op6;
        s   = 32'(r.rs) << 21;
        t   = 32'(r.rt) << 16;
        d   = 32'(r.rd) << 11;
        i   = 32'(r.imm);
        op6 = 32'd1 << 26;
        case (r.op)
            4'd0:  return s + t + d + 32'd33;
            4'd1:  return s + t + d + 32'd35;
            4'd2:  return s + 32'd8;
            4'd3:  return 32'd12;
            4'd4:  return 32'd13 * op6 + s + t + i;
            4'd5:  return 32'd15 * op6 + t + i;
            4'd6:  return 32'd35 * op6 + s + t + i;
            4'd7:  return 32'd43 * op6 + s + t + i;
            4'd8:  return 32'd4 * op6 + s + t + i;
            4'd9:  return 32'd2 * op6 + 32'(r.tgt);
            4'd10: return 32'd3 * op6 + 32'(r.tgt);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ei, ea;
        ei = (mq.size() != 0) ? mq[0][63:32] : 32'd0;
        ea = (mq.size() != 0) ? mq[0][31:0]  : 32'd0;
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_instr", out_instr, ei);
        chk("out_addr", out_addr, ea);
        chk("err", 32'(err), 32'(m_err));
    endtask

    // One clock: drive, check in_ready, advance model, clock, check outputs
    task automatic step(req_t r, logic ordy, logic fl);
        logic exp_ready, do_pop, bad;
        in_valid  = r.v;
        in_op     = r.op;
        in_rs     = r.rs;
        in_rt     = r.rt;
        in_rd     = r.rd;
        in_imm16  = r.imm;
        in_target = r.tgt;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_ready = (mq.size() < 4) && !fl;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        do_pop = (mq.size() != 0) && ordy;
        if (fl) begin
            mq.delete();
            m_addr = BASE;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (r.v && exp_ready) begin
                bad = 1'b0;
`ifdef ENCODER_STRICT_EN
                bad = (r.op > 4'd10);
`endif
                if (bad) m_err = 1'b1;
                else begin
                    mq.push_back({ref_enc(r), m_addr});
                    m_addr = m_addr + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic req_t mk(logic v, logic [3:0] op, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic [15:0] imm, logic [25:0] tgt);
        req_t r;
        r.v = v; r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.imm = imm; r.tgt = tgt;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[11];
        req_t        idle, r;
        logic [31:0] a0;

        idle = mk(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        // Unused fields carry junk to prove they never leak into the word
        tbl[0]  = '{mk(1, 4'd0,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF), 32'h0022_1821};
        tbl[1]  = '{mk(1, 4'd4,  5'd0,  5'd1,  5'd31, 16'h1234, 26'h3FFFFFF), 32'h3401_1234};
        tbl[2]  = '{mk(1, 4'd5,  5'd7,  5'd1,  5'd31, 16'h8000, 26'h1555555), 32'h3C01_8000};
        tbl[3]  = '{mk(1, 4'd6,  5'd29, 5'd8,  5'd17, 16'h0004, 26'h2AAAAAA), 32'h8FA8_0004};
        tbl[4]  = '{mk(1, 4'd8,  5'd1,  5'd2,  5'd31, 16'hFFFF, 26'h3FFFFFF), 32'h1022_FFFF};
        tbl[5]  = '{mk(1, 4'd3,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF), 32'h0000_000C};
        tbl[6]  = '{mk(1, 4'd10, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000C04), 32'h0C00_0C04};
        tbl[7]  = '{mk(1, 4'd1,  5'd4,  5'd5,  5'd6,  16'hFFFF, 26'h3FFFFFF), 32'h0085_3023};
        tbl[8]  = '{mk(1, 4'd2,  5'd31, 5'd7,  5'd9,  16'h1234, 26'h3FFFFFF), 32'h03E0_0008};
        tbl[9]  = '{mk(1, 4'd7,  5'd2,  5'd3,  5'd31, 16'h0010, 26'h3FFFFFF), 32'hAC43_0010};
        tbl[10] = '{mk(1, 4'd9,  5'd1,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF), 32'h0BFF_FFFF};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm16 = '0; in_target = '0;
        w_valid = 1'b0; w_out_ready = 1'b0; w_op = 4'd3;
        mq.delete(); m_addr = BASE; m_err = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Address wrap on a second instance based just below 2^32
        w_valid = 1'b1;
        repeat (3) step(idle, 1'b0, 1'b0);
        w_valid = 1'b0;
        chk("wrap_count", 32'(w_count), 32'd3);
        chk("wrap_instr", w_instr, 32'h0000_000C);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
        w_out_ready = 1'b1;
        step(idle, 1'b0, 1'b0);
        chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        step(idle, 1'b0, 1'b0);
        chk("wrap_addr2", w_addr, 32'h0000_0000);
        step(idle, 1'b0, 1'b0);
        chk("wrap_empty", 32'(w_out_valid), 32'd0);
        w_out_ready = 1'b0;

        // Back-to-back table with out_ready high: one word per cycle
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, 1'b1, 1'b0);
            chk("tbl_instr", out_instr, tbl[i].exp);
            chk("tbl_addr", out_addr, BASE + 32'(4 * i));
            chk("tbl_count", 32'(count), 32'd1);
        end
        step(idle, 1'b1, 1'b0);

        // Flush with two words queued and a same-cycle pop request
        step(tbl[0].r, 1'b0, 1'b0);
        step(tbl[1].r, 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd2);
        step(tbl[2].r, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        step(tbl[3].r, 1'b0, 1'b0);
        chk("post_flush_addr", out_addr, BASE);
        step(idle, 1'b1, 1'b1);

        // Full FIFO under back-pressure: fifth request waits for a pop
        for (int i = 0; i < 5; i++) step(tbl[i].r, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_head", out_instr, tbl[0].exp);
        chk("full_ready", 32'(in_ready), 32'd0);
        step(tbl[4].r, 1'b1, 1'b0);
        step(tbl[4].r, 1'b1, 1'b0);
        chk("refill_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) step(idle, 1'b1, 1'b0);
        chk("drain_count", 32'(count), 32'd0);

        // Invalid op followed by a valid one
        a0 = m_addr;
        step(mk(1, 4'd12, 5'd3, 5'd3, 5'd3, 16'h5555, 26'h1234567), 1'b0, 1'b0);
        step(tbl[0].r, 1'b0, 1'b0);
`ifdef ENCODER_STRICT_EN
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_count", 32'(count), 32'd1);
        chk("bad_next_addr", out_addr, a0);
        chk("bad_next_instr", out_instr, 32'h0022_1821);
`else
        chk("bad_err", 32'(err), 32'd0);
        chk("bad_count", 32'(count), 32'd2);
        chk("bad_nop_addr", out_addr, a0);
        chk("bad_nop_instr", out_instr, 32'h0000_0000);
`endif
        step(tbl[1].r, 1'b0, 1'b0);
        step(tbl[2].r, 1'b0, 1'b0);

        // Asynchronous reset mid-stream, between clock edges
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_instr", out_instr, 32'd0);
        chk("arst_addr", out_addr, 32'd0);
        mq.delete(); m_addr = BASE; m_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(tbl[0].r, 1'b0, 1'b0);
        chk("post_rst_addr", out_addr, 32'h0000_3000);
        step(idle, 1'b1, 1'b1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r.v   = ($urandom_range(0, 9) < 7);
            r.op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15))
                                                : 4'($urandom_range(0, 10));
            r.rs  = 5'($urandom);
            r.rt  = 5'($urandom);
            r.rd  = 5'($urandom);
            r.imm = 16'($urandom);
            r.tgt = 26'($urandom);
            step(r, ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
